// File: rtl/usrt_pkg.sv
// usrt_pkg: state encodings and widths shared by the USRT transmit and receive shifters
package usrt_pkg;

    localparam int USRT_DATA_BITS = 8;
    localparam int USRT_BAUD_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_FINISH = 3'd5
    } usrt_state_e;

endpackage

// File: rtl/usrt_bitcnt.sv
// usrt_bitcnt: bit-period counter; latches the period on load and ticks on the last cycle of each bit
module usrt_bitcnt
    import usrt_pkg::*;
(
    input  logic                   i_Pclk,
    input  logic                   i_Rst,
    input  logic                   i_Load,
    input  logic [USRT_BAUD_W-1:0] i_Baud,
    input  logic                   i_Run,
    output logic                   o_Tick
);

    logic [USRT_BAUD_W-1:0] cnt, lim;

    assign o_Tick = i_Run && cnt == lim;

    // lim holds B-1, so baud values 0 and 1 both give a one-cycle bit
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt <= '0;
            lim <= '0;
        end else if (i_Load) begin
            cnt <= '0;
            lim <= i_Baud == '0 ? '0 : i_Baud - 1'b1;
        end else if (i_Run) begin
            cnt <= o_Tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/txshift.sv
// txshift: USRT transmitter, start + 8 data bits LSB first + stop, idle-high line.
// Define TXSHIFT_PARITY_EN to insert an even-parity bit after the data bits.
module txshift
    import usrt_pkg::*;
(
    input  logic                      i_Pclk,
    input  logic                      i_Rst,
    input  logic [USRT_BAUD_W-1:0]    i_Baud,
    input  logic                      i_Enable,
    input  logic                      i_Tx_Start,
    input  logic [USRT_DATA_BITS-1:0] i_Data,
    output logic                      o_Tx_Serial,
    output logic                      o_Busy,
    output logic                      o_Done
);

    localparam int IDX_W = $clog2(USRT_DATA_BITS);

    usrt_state_e               state, state_d;
    logic [IDX_W-1:0]          idx, idx_d;
    logic [USRT_DATA_BITS-1:0] data, data_d;
    logic                      tx_d, busy_d, done_d;
    logic                      accept, run, tick;

    assign accept = state == S_IDLE && i_Tx_Start && i_Enable;
    assign run    = state inside {S_START, S_DATA, S_PARITY, S_STOP};

    usrt_bitcnt u_bitcnt (
        .i_Pclk (i_Pclk),
        .i_Rst  (i_Rst),
        .i_Load (accept),
        .i_Baud (i_Baud),
        .i_Run  (run),
        .o_Tick (tick)
    );

    always_comb begin
        state_d = state;
        idx_d   = idx;
        data_d  = data;
        tx_d    = o_Tx_Serial;
        busy_d  = o_Busy;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    data_d  = i_Data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (tick) begin
                idx_d   = '0;
                tx_d    = data[0];
                state_d = S_DATA;
            end
            S_DATA: if (tick) begin
                if (idx == IDX_W'(USRT_DATA_BITS - 1)) begin
                    idx_d   = '0;
`ifdef TXSHIFT_PARITY_EN
                    tx_d    = ^data;
                    state_d = S_PARITY;
`else
                    tx_d    = 1'b1;
                    state_d = S_STOP;
`endif
                end else begin
                    idx_d = idx + 1'b1;
                    tx_d  = data[idx_d];
                end
            end
`ifdef TXSHIFT_PARITY_EN
            S_PARITY: if (tick) begin
                tx_d    = 1'b1;
                state_d = S_STOP;
            end
`endif
            S_STOP: if (tick) begin
                done_d  = 1'b1;
                state_d = S_FINISH;
            end
            S_FINISH: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            data        <= '0;
            o_Tx_Serial <= 1'b1;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            data        <= data_d;
            o_Tx_Serial <= tx_d;
            o_Busy      <= busy_d;
            o_Done      <= done_d;
        end
    end

endmodule

// File: tb/tb_txshift.sv
// tb_txshift: directed frames checked cycle by cycle as {line, busy, done}
module tb_txshift;

`ifdef TXSHIFT_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       i_Pclk = 1'b0;
    logic       i_Rst = 1'b0;
    logic [7:0] i_Baud = 8'd4;
    logic       i_Enable = 1'b1;
    logic       i_Tx_Start = 1'b0;
    logic [7:0] i_Data = 8'h00;
    logic       o_Tx_Serial, o_Busy, o_Done;
    int         n_vec = 0;
    int         n_err = 0;

    txshift dut (
        .i_Pclk      (i_Pclk),
        .i_Rst       (i_Rst),
        .i_Baud      (i_Baud),
        .i_Enable    (i_Enable),
        .i_Tx_Start  (i_Tx_Start),
        .i_Data      (i_Data),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done)
    );

    always #5 i_Pclk = ~i_Pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // j = cycles after the accepting edge E0
    function automatic logic [2:0] exp_vec(input logic [7:0] d, input int b, input int j);
        logic line;
        line = 1'b1;
        if (j < b) line = 1'b0;
        else if (j < 9 * b) line = d[j / b - 1];
`ifdef TXSHIFT_PARITY_EN
        else if (j < 10 * b) line = ^d;
`endif
        return {line, j <= NB * b, j == NB * b};
    endfunction

    // mode 0: plain frame, 1: mid-frame disturbances, 2: async reset during bit 3
    task automatic run_frame(input logic [7:0] d, input logic [7:0] baud, input int mode);
        int b;
        b = baud == 8'd0 ? 1 : int'(baud);
        i_Data = d;
        i_Baud = baud;
        i_Tx_Start = 1'b1;
        @(posedge i_Pclk); #1;
        i_Tx_Start = 1'b0;
        for (int j = 0; j <= NB * b + 1; j++) begin
            if (mode == 2 && j == 4 * b + 1) begin
                #2 i_Rst = 1'b1;
                #1 chk("rst_mid_data", {o_Tx_Serial, o_Busy, o_Done}, 3'b100);
                @(negedge i_Pclk);
                i_Rst = 1'b0;
                @(posedge i_Pclk); #1;
                chk("idle_after_rst", {o_Tx_Serial, o_Busy, o_Done}, 3'b100);
                return;
            end
            if (mode == 1 && j == 2 * b + 1) begin
                i_Tx_Start = 1'b1;
                i_Data = 8'h00;
                i_Baud = 8'd7;
                i_Enable = 1'b0;
            end
            chk($sformatf("frame %02h b%0d c%0d", d, b, j), {o_Tx_Serial, o_Busy, o_Done}, exp_vec(d, b, j));
            @(posedge i_Pclk); #1;
        end
    endtask

    initial begin
        #2 i_Rst = 1'b1;
        #1 chk("reset_async", {o_Tx_Serial, o_Busy, o_Done}, 3'b100);
        repeat (2) @(posedge i_Pclk);
        @(negedge i_Pclk);
        i_Rst = 1'b0;
        @(posedge i_Pclk); #1;
        chk("reset_idle", {o_Tx_Serial, o_Busy, o_Done}, 3'b100);
        run_frame(8'hA5, 8'd4, 2);
        run_frame(8'h3C, 8'd4, 0);
        run_frame(8'hA5, 8'd4, 0);
        run_frame(8'hFF, 8'd0, 0);
        run_frame(8'hFF, 8'd1, 0);
        run_frame(8'h5A, 8'd3, 1);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("no_second_frame c%0d", k), {o_Tx_Serial, o_Busy, o_Done}, 3'b100);
            @(posedge i_Pclk); #1;
        end
        i_Tx_Start = 1'b0;
        i_Enable = 1'b1;
        i_Baud = 8'd2;
        i_Data = 8'h01;
        i_Tx_Start = 1'b1;
        @(posedge i_Pclk); #1;
        i_Data = 8'h80;
        for (int j = 0; j < 2 * (NB * 2 + 2); j++) begin
            if (j == NB * 2 + 3) i_Tx_Start = 1'b0;
            chk($sformatf("b2b c%0d", j), {o_Tx_Serial, o_Busy, o_Done},
                j < NB * 2 + 2 ? exp_vec(8'h01, 2, j) : exp_vec(8'h80, 2, j - (NB * 2 + 2)));
            @(posedge i_Pclk); #1;
        end
`ifdef TXSHIFT_PARITY_EN
        run_frame(8'h07, 8'd3, 0);
        run_frame(8'h03, 8'd3, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
